// File: rtl/ex_stage.sv
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage of a 5-stage MIPS-style pipeline.
//                - Input pipeline register fed from decode (hold / bubble / load)
//                - One-hot operand selection and one-hot ALU
//                - Data-memory request generation with byte-lane steering
//                - Forwarding bus back to decode and load-use indication
//                - Multi-cycle restoring divider (div / divu) writing HI/LO
//  Ports       :
//    clk              rising-edge clock
//    rst              synchronous, active-high reset
//    stall[5:0]       pipeline stall vector (bit2 EX hold, bit3 MEM hold)
//    id_to_ex_bus     164-bit decode bundle
//    ex_to_mem_bus    81-bit bundle to the memory stage
//    ex_to_rf_bus     38-bit {we, waddr, wdata} forward to decode
//    ex_is_load       EX currently holds a load
//    data_sram_*      data memory request (en, byte wen, addr, wdata)
//    hilo_bus         65-bit {we, hi, lo} divider result
//    stallreq_for_ex  EX asks the pipeline to stall (divider running)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [163:0] id_to_ex_bus,
  output logic [80:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         ex_is_load,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [64:0]  hilo_bus,
  output logic         stallreq_for_ex
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_SB      = 6'b101000;
  localparam logic [5:0] OPC_SH      = 6'b101001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  // --------------------------------------------------------------------------
  // Input pipeline register
  // When EX is held but MEM keeps moving, a bubble is loaded here so the
  // instruction in EX is not issued to MEM twice.
  // --------------------------------------------------------------------------
  logic [163:0] ex_bus;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_bus <= '0;
    end else if (stall[2] && !stall[3]) begin
      ex_bus <= '0;
    end else if (!stall[2]) begin
      ex_bus <= id_to_ex_bus;
    end
  end

  // --------------------------------------------------------------------------
  // Field extraction
  // --------------------------------------------------------------------------
  logic [4:0]  mem_op;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        sel_rf_res;
  logic [31:0] rdata1;
  logic [31:0] rdata2;

  assign mem_op     = ex_bus[163:159];
  assign pc         = ex_bus[158:127];
  assign inst       = ex_bus[126:95];
  assign alu_op     = ex_bus[94:83];
  assign sel_src1   = ex_bus[82:80];
  assign sel_src2   = ex_bus[79:76];
  assign ram_en     = ex_bus[75];
  assign ram_wen    = ex_bus[74:71];
  assign rf_we      = ex_bus[70];
  assign rf_waddr   = ex_bus[69:65];
  assign sel_rf_res = ex_bus[64];
  assign rdata1     = ex_bus[63:32];
  assign rdata2     = ex_bus[31:0];

  logic [5:0] opcode;
  logic [5:0] funct;
  assign opcode = inst[31:26];
  assign funct  = inst[5:0];

  // --------------------------------------------------------------------------
  // Operand selection (one-hot select, implemented as AND-OR)
  // --------------------------------------------------------------------------
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] src1;
  logic [31:0] src2;

  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};

  always_comb begin
    src1 = '0;
    if (sel_src1[0]) src1 = src1 | rdata1;
    if (sel_src1[1]) src1 = src1 | pc;
    if (sel_src1[2]) src1 = src1 | {27'b0, inst[10:6]};
  end

  always_comb begin
    src2 = '0;
    if (sel_src2[0]) src2 = src2 | rdata2;
    if (sel_src2[1]) src2 = src2 | imm_sext;
    if (sel_src2[2]) src2 = src2 | 32'd8;
    if (sel_src2[3]) src2 = src2 | imm_zext;
  end

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [4:0]  shamt;
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sra_res;
  logic [31:0] ex_result;

  assign shamt    = src1[4:0];
  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {31'b0, ($signed(src1) < $signed(src2))};
  assign sltu_res = {31'b0, (src1 < src2)};
  assign sra_res  = $unsigned($signed(src2) >>> shamt);

  // alu_op is one-hot; an all-zero op (bubble, div) yields zero.
  always_comb begin
    ex_result = '0;
    if (alu_op[0])  ex_result = ex_result | add_res;
    if (alu_op[1])  ex_result = ex_result | sub_res;
    if (alu_op[2])  ex_result = ex_result | slt_res;
    if (alu_op[3])  ex_result = ex_result | sltu_res;
    if (alu_op[4])  ex_result = ex_result | (src1 & src2);
    if (alu_op[5])  ex_result = ex_result | ~(src1 | src2);
    if (alu_op[6])  ex_result = ex_result | (src1 | src2);
    if (alu_op[7])  ex_result = ex_result | (src1 ^ src2);
    if (alu_op[8])  ex_result = ex_result | (src2 << shamt);
    if (alu_op[9])  ex_result = ex_result | (src2 >> shamt);
    if (alu_op[10]) ex_result = ex_result | sra_res;
    if (alu_op[11]) ex_result = ex_result | {src2[15:0], 16'b0};
  end

  // --------------------------------------------------------------------------
  // Data memory request
  // Store width comes from the opcode; anything that writes but is not
  // sb/sh is treated as a full-word store. Misalignment is not trapped here.
  // --------------------------------------------------------------------------
  logic is_store;
  assign is_store = |ram_wen;

  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = rdata2;
    if (is_store) begin
      if (opcode == OPC_SB) begin
        data_sram_wen   = 4'b0001 << ex_result[1:0];
        data_sram_wdata = {4{rdata2[7:0]}};
      end else if (opcode == OPC_SH) begin
        data_sram_wen   = ex_result[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{rdata2[15:0]}};
      end else begin
        data_sram_wen   = 4'b1111;
        data_sram_wdata = rdata2;
      end
    end
  end

  assign data_sram_en   = ram_en | is_store;
  assign data_sram_addr = ex_result;

  // --------------------------------------------------------------------------
  // Downstream and forwarding buses
  // A load's value is not known until MEM, so it is never forwarded from EX.
  // --------------------------------------------------------------------------
  assign ex_to_mem_bus = {mem_op, pc, ram_en, ram_wen, sel_rf_res,
                          rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus  = {rf_we & ~sel_rf_res, rf_waddr, ex_result};
  assign ex_is_load    = sel_rf_res;

  // --------------------------------------------------------------------------
  // Divider (restoring, one quotient bit per cycle)
  // --------------------------------------------------------------------------
  logic is_div_signed;
  logic is_div_unsigned;
  logic is_div;

  assign is_div_signed   = (opcode == OPC_SPECIAL) && (funct == FUNCT_DIV);
  assign is_div_unsigned = (opcode == OPC_SPECIAL) && (funct == FUNCT_DIVU);
  assign is_div          = is_div_signed | is_div_unsigned;

  logic [1:0]  div_state;
  logic [31:0] div_quot;      // holds the dividend at start, quotient at end
  logic [31:0] div_rem;
  logic [31:0] div_divisor;
  logic [4:0]  div_cnt;
  logic        div_done_flag; // blocks a restart on the same, still-held div
  logic        div_first;     // first cycle in DONE: the only HI/LO write
  logic        div_neg_q;
  logic        div_neg_r;
  logic        div_by_zero;

  logic        div_start;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign div_start = (div_state == DIV_IDLE) && is_div && !div_done_flag;
  assign neg_a     = is_div_signed & rdata1[31];
  assign neg_b     = is_div_signed & rdata2[31];
  assign abs_a     = neg_a ? (32'd0 - rdata1) : rdata1;
  assign abs_b     = neg_b ? (32'd0 - rdata2) : rdata2;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. An explicit compare is
  // used so the divide-by-zero case (divisor 0) still behaves: every step
  // "fits", the quotient fills with ones and the remainder ends as |a|.
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic        rem_ge;
  logic [31:0] rem_next;

  assign rem_shift = {div_rem, div_quot[31]};
  assign rem_diff  = rem_shift - {1'b0, div_divisor};
  assign rem_ge    = (rem_shift >= {1'b0, div_divisor});
  assign rem_next  = rem_ge ? rem_diff[31:0] : rem_shift[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state     <= DIV_IDLE;
      div_quot      <= '0;
      div_rem       <= '0;
      div_divisor   <= '0;
      div_cnt       <= '0;
      div_done_flag <= 1'b0;
      div_first     <= 1'b0;
      div_neg_q     <= 1'b0;
      div_neg_r     <= 1'b0;
      div_by_zero   <= 1'b0;
    end else begin
      case (div_state)
        DIV_IDLE: begin
          if (div_start) begin
            div_quot    <= abs_a;
            div_divisor <= abs_b;
            div_rem     <= '0;
            div_cnt     <= '0;
            div_neg_q   <= neg_a ^ neg_b;
            div_neg_r   <= neg_a;
            div_by_zero <= (rdata2 == 32'd0);
            div_state   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          div_rem  <= rem_next;
          div_quot <= {div_quot[30:0], rem_ge};
          div_cnt  <= div_cnt + 5'd1;
          if (div_cnt == 5'd31) begin
            div_state     <= DIV_DONE;
            div_done_flag <= 1'b1;
            div_first     <= 1'b1;
          end
        end
        DIV_DONE: begin
          div_first <= 1'b0;
          if (!stall[2]) begin
            div_state     <= DIV_IDLE;
            div_done_flag <= 1'b0;
          end
        end
        default: begin
          div_state <= DIV_IDLE;
        end
      endcase
    end
  end

  // Sign correction. Divide-by-zero forces LO to all ones; the remainder
  // path already reproduces the original dividend in that case.
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic        hilo_we;

  assign quot_fix = div_by_zero ? 32'hFFFF_FFFF
                                : (div_neg_q ? (32'd0 - div_quot) : div_quot);
  assign rem_fix  = div_neg_r ? (32'd0 - div_rem) : div_rem;
  assign hilo_we  = (div_state == DIV_DONE) && div_first;

  assign hilo_bus        = hilo_we ? {1'b1, rem_fix, quot_fix} : 65'd0;
  assign stallreq_for_ex = div_start || (div_state == DIV_BUSY);

  // Bits of the inputs that this stage has no use for.
  logic unused_bits;
  assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16], rem_diff[32]};

endmodule

`default_nettype wire
